crossbar_egress_collector: RTL and testbench
============================================

CROSSBAR_EGRESS_COLLECTOR -- requirements
Module: crossbar_egress_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each crossbar output data word.
REQ-002 Parameter NUM_PORTS, default 8: number of crossbar output ports collected.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of two, >=2): per-port buffer depth.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 port_data  input  NUM_PORTS*DATA_WIDTH  crossbar output words, port p in bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-007 port_valid  input  NUM_PORTS  per-port word-valid strobes, one word per asserted bit per cycle.
REQ-008 m_data  output  DATA_WIDTH  merged stream data.
REQ-009 m_port  output  clog2(NUM_PORTS)  source port index of m_data.
REQ-010 m_valid  output  1  merged stream word valid.
REQ-011 m_ready  input  1  downstream accept; transfer when m_valid && m_ready.
REQ-012 fifo_full  output  NUM_PORTS  per-port buffer full flags.
REQ-013 drop_count  output  16  saturating count of discarded words.
REQ-014 collector_busy  output  1  high when any buffer is non-empty or m_valid is high.

Function
REQ-015 Capture: for each port p with port_valid[p]=1 at a rising edge, the word SHALL be pushed into buffer p if not full, or if full with a same-edge pop from buffer p.
REQ-016 Drop: a word arriving at a full buffer with no same-edge pop SHALL be discarded; drop_count SHALL increase by the number of ports dropping at that edge, saturating at 16'hFFFF.
REQ-017 Buffers SHALL be FIFO per port; word order within one port is preserved end to end.
REQ-018 Output register: m_data/m_port/m_valid SHALL be registered; the register loads when empty (m_valid=0) or when a transfer occurs at the same edge.
REQ-019 Arbitration: at a load opportunity, the first non-empty buffer in round-robin order starting at (last_granted+1) mod NUM_PORTS SHALL be popped into the output register; last_granted updates to that port.
REQ-020 If no buffer is non-empty at a load opportunity, m_valid SHALL go to 0 (after a transfer) or stay 0.
REQ-021 Latency: a word captured at edge k into an empty collector (m_valid=0) SHALL appear with m_valid=1 after edge k+1.
REQ-022 Stall: while m_valid=1 and m_ready=0, m_data, m_port and m_valid SHALL remain stable and no buffer SHALL pop.
REQ-023 fifo_full[p] SHALL reflect registered occupancy of buffer p == FIFO_DEPTH.
REQ-024 Throughput: with m_ready held 1 and continuous input, one word per cycle SHALL be delivered.
REQ-025 Pointer and occupancy counters SHALL wrap modulo FIFO_DEPTH without loss; occupancy uses clog2(FIFO_DEPTH)+1 bits.

Reset
REQ-026 On rst=1, asynchronously: all buffers empty, fifo_full=0, m_valid=0, m_data=0, m_port=0, drop_count=0, collector_busy=0, last_granted=NUM_PORTS-1 (port 0 wins first).
REQ-027 Reset asserted mid-transfer SHALL discard all buffered and in-flight words; port_valid is ignored while rst=1.

Structure
REQ-028 Package crossbar_pkg SHALL hold default DATA_WIDTH/NUM_PORTS constants and the port-index width function/typedef shared with the crossbar host.
REQ-029 One sub-module crossbar_egress_fifo (synchronous FIFO, push/pop/full/empty/data) SHALL be instantiated NUM_PORTS times.

Verification
REQ-030 Single word: after reset, port 3 sends 8'hA5 with m_ready=1 -> m_valid=1, m_data=8'hA5, m_port=3 one cycle after capture, then m_valid=0.
REQ-031 Round-robin: ports 0,2,5 each send one word at the same edge, m_ready=1 -> delivered in order 0,2,5 on consecutive cycles.
REQ-032 Overflow: m_ready=0, port 1 sends 6 words (FIFO_DEPTH=4) -> fifo_full[1]=1, buffer holds 4 words, m_valid=1 with word 1, drop_count=1; release m_ready -> words 1..5 delivered in order.
REQ-033 Stall: m_valid=1, m_ready=0 for 10 cycles with other ports active -> m_data/m_port unchanged throughout.
REQ-034 Saturation: force 70000 drops -> drop_count holds 16'hFFFF.
REQ-035 Reset mid-operation: rst pulsed with 3 ports partially full -> all outputs return to reset values immediately, no stale word appears afterwards.

Source files
------------

// File: rtl/crossbar_pkg.sv
// Shared crossbar constants and the port-index width helper used by the
// egress collector and the crossbar host.
package crossbar_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_NUM_PORTS  = 8;

    // A single-port crossbar still needs a 1-bit index to stay legal.
    function automatic int port_idx_width(input int num_ports);
        return (num_ports <= 1) ? 1 : $clog2(num_ports);
    endfunction

    typedef logic [port_idx_width(DEFAULT_NUM_PORTS)-1:0] port_idx_t;

endpackage

// File: rtl/crossbar_egress_collector_if.sv
// Bus bundle between crossbar outputs, the egress collector and its downstream sink.
interface crossbar_egress_collector_if
    import crossbar_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_PORTS  = DEFAULT_NUM_PORTS
);
    localparam int PW = port_idx_width(NUM_PORTS);

    logic [NUM_PORTS*DATA_WIDTH-1:0] port_data;
    logic [NUM_PORTS-1:0]            port_valid;
    logic [DATA_WIDTH-1:0]           m_data;
    logic [PW-1:0]                   m_port;
    logic                            m_valid;
    logic                            m_ready;
    logic [NUM_PORTS-1:0]            fifo_full;
    logic [15:0]                     drop_count;
    logic                            collector_busy;

    modport master (
        input  port_data, port_valid, m_ready,
        output m_data, m_port, m_valid, fifo_full, drop_count, collector_busy
    );

    modport slave (
        output port_data, port_valid, m_ready,
        input  m_data, m_port, m_valid, fifo_full, drop_count, collector_busy
    );

endinterface

// File: rtl/crossbar_egress_fifo.sv
// Per-port synchronous FIFO; a push into a full FIFO is accepted only when
// a pop happens on the same edge.
module crossbar_egress_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  do_push;
    logic                  do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/crossbar_egress_collector.sv
// Buffers every crossbar output port and merges them round-robin into one
// registered valid/ready stream, counting words lost to full buffers.
module crossbar_egress_collector
    import crossbar_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_PORTS  = DEFAULT_NUM_PORTS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    crossbar_egress_collector_if.master bus
);
    localparam int PW = port_idx_width(NUM_PORTS);

    logic [NUM_PORTS-1:0]  fifo_empty;
    logic [NUM_PORTS-1:0]  fifo_full_int;
    logic [NUM_PORTS-1:0]  pop;
    logic [NUM_PORTS-1:0]  drop;
    logic [DATA_WIDTH-1:0] pop_data [NUM_PORTS];
    logic [PW-1:0]         last_granted;
    logic [PW-1:0]         grant;
    logic                  grant_valid;
    logic                  load;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic [PW-1:0]         m_port_q;
    logic                  m_valid_q;
    logic [15:0]           drop_count_q;
    logic [16:0]           drop_sum;
    logic [15:0]           drop_next;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        crossbar_egress_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (bus.port_valid[p]),
            .push_data (bus.port_data[p*DATA_WIDTH +: DATA_WIDTH]),
            .pop       (pop[p]),
            .pop_data  (pop_data[p]),
            .full      (fifo_full_int[p]),
            .empty     (fifo_empty[p])
        );
    end

    assign load = !m_valid_q || bus.m_ready;

    // Search starts just after the last winner so every port gets a turn.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(last_granted) + 1 + i) % NUM_PORTS;
            if (!grant_valid && !fifo_empty[idx]) begin
                grant       = PW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    assign pop  = (load && grant_valid) ? (NUM_PORTS'(1) << grant) : '0;
    assign drop = bus.port_valid & fifo_full_int & ~pop;

    always_comb begin
        drop_sum = {1'b0, drop_count_q};
        for (int p = 0; p < NUM_PORTS; p++) begin
            drop_sum = drop_sum + 17'(drop[p]);
        end
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data_q     <= '0;
            m_port_q     <= '0;
            m_valid_q    <= 1'b0;
            last_granted <= PW'(NUM_PORTS - 1);
            drop_count_q <= '0;
        end else begin
            if (load) begin
                m_valid_q <= grant_valid;
                if (grant_valid) begin
                    m_data_q     <= pop_data[grant];
                    m_port_q     <= grant;
                    last_granted <= grant;
                end
            end
            drop_count_q <= drop_next;
        end
    end

    assign bus.m_data         = m_data_q;
    assign bus.m_port         = m_port_q;
    assign bus.m_valid        = m_valid_q;
    assign bus.fifo_full      = fifo_full_int;
    assign bus.drop_count     = drop_count_q;
    assign bus.collector_busy = m_valid_q || !(&fifo_empty);

endmodule

// File: tb/tb_crossbar_egress_collector.sv
// Directed bench for the crossbar egress collector: single word, round-robin,
// overflow, stall, drop saturation and mid-operation reset.
module tb_crossbar_egress_collector;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    crossbar_egress_collector_if #(.DATA_WIDTH(8), .NUM_PORTS(8)) bus ();

    crossbar_egress_collector #(
        .DATA_WIDTH (8),
        .NUM_PORTS  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int p, input logic [7:0] d);
        bus.port_data[p*8 +: 8] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
        check({tag, "_m_data"}, 32'(bus.m_data), 32'd0);
        check({tag, "_m_port"}, 32'(bus.m_port), 32'd0);
        check({tag, "_fifo_full"}, 32'(bus.fifo_full), 32'd0);
        check({tag, "_drop_count"}, 32'(bus.drop_count), 32'd0);
        check({tag, "_busy"}, 32'(bus.collector_busy), 32'd0);
    endtask

    initial begin
        n_cmp          = 0;
        n_err          = 0;
        rst            = 1'b1;
        bus.m_ready    = 1'b0;
        bus.port_valid = '0;
        bus.port_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_reset("reset");
        rst = 1'b0;

        // Single word from port 3
        bus.m_ready = 1'b1;
        set_word(3, 8'hA5);
        bus.port_valid = 8'h08;
        tick();
        bus.port_valid = '0;
        check("single_capture_valid", 32'(bus.m_valid), 32'd0);
        check("single_capture_busy", 32'(bus.collector_busy), 32'd1);
        tick();
        check("single_valid", 32'(bus.m_valid), 32'd1);
        check("single_data", 32'(bus.m_data), 32'hA5);
        check("single_port", 32'(bus.m_port), 32'd3);
        tick();
        check("single_after_valid", 32'(bus.m_valid), 32'd0);
        check("single_after_busy", 32'(bus.collector_busy), 32'd0);

        // Round-robin across ports 0, 2, 5 captured on one edge
        do_reset();
        set_word(0, 8'h10);
        set_word(2, 8'h20);
        set_word(5, 8'h50);
        bus.port_valid = 8'b0010_0101;
        tick();
        bus.port_valid = '0;
        tick();
        check("rr0_valid", 32'(bus.m_valid), 32'd1);
        check("rr0_port", 32'(bus.m_port), 32'd0);
        check("rr0_data", 32'(bus.m_data), 32'h10);
        tick();
        check("rr1_port", 32'(bus.m_port), 32'd2);
        check("rr1_data", 32'(bus.m_data), 32'h20);
        tick();
        check("rr2_port", 32'(bus.m_port), 32'd5);
        check("rr2_data", 32'(bus.m_data), 32'h50);
        tick();
        check("rr_end_valid", 32'(bus.m_valid), 32'd0);

        // Overflow on port 1 with the sink stalled
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_word(1, 8'(8'h61 + i));
            bus.port_valid = 8'h02;
            tick();
        end
        bus.port_valid = '0;
        check("ovf_full", 32'(bus.fifo_full), 32'h02);
        check("ovf_valid", 32'(bus.m_valid), 32'd1);
        check("ovf_data", 32'(bus.m_data), 32'h61);
        check("ovf_port", 32'(bus.m_port), 32'd1);
        check("ovf_drop", 32'(bus.drop_count), 32'd1);
        bus.m_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            check("ovf_drain_valid", 32'(bus.m_valid), 32'd1);
            check("ovf_drain_data", 32'(bus.m_data), 32'(8'h61 + i));
            check("ovf_drain_port", 32'(bus.m_port), 32'd1);
        end
        tick();
        check("ovf_end_valid", 32'(bus.m_valid), 32'd0);
        check("ovf_end_full", 32'(bus.fifo_full), 32'd0);

        // Stall with ports 0 and 6 streaming underneath
        bus.m_ready = 1'b0;
        set_word(4, 8'h44);
        bus.port_valid = 8'h10;
        tick();
        bus.port_valid = '0;
        tick();
        check("stall_start_valid", 32'(bus.m_valid), 32'd1);
        check("stall_start_data", 32'(bus.m_data), 32'h44);
        for (int i = 0; i < 10; i++) begin
            set_word(0, 8'(8'hC0 + i));
            set_word(6, 8'(8'hB0 + i));
            bus.port_valid = 8'h41;
            tick();
            check("stall_hold", {15'd0, bus.m_valid, 5'd0, bus.m_port, bus.m_data}, {15'd0, 1'b1, 5'd0, 3'd4, 8'h44});
        end
        bus.port_valid = '0;
        check("stall_drop", 32'(bus.drop_count), 32'd13);
        check("stall_full", 32'(bus.fifo_full), 32'h41);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall_drain_p6", {21'd0, bus.m_port, bus.m_data}, {21'd0, 3'd6, 8'(8'hB0 + i)});
            tick();
            check("stall_drain_p0", {21'd0, bus.m_port, bus.m_data}, {21'd0, 3'd0, 8'(8'hC0 + i)});
        end
        tick();
        check("stall_end_valid", 32'(bus.m_valid), 32'd0);

        // Drop counter saturation
        do_reset();
        bus.m_ready = 1'b0;
        for (int p = 0; p < 8; p++) set_word(p, 8'hEE);
        bus.port_valid = 8'hFF;
        repeat (5) tick();
        check("sat_drop_e5", 32'(bus.drop_count), 32'd7);
        tick();
        check("sat_drop_e6", 32'(bus.drop_count), 32'd15);
        repeat (8800) tick();
        check("sat_drop_max", 32'(bus.drop_count), 32'hFFFF);
        tick();
        check("sat_drop_hold", 32'(bus.drop_count), 32'hFFFF);
        check("sat_full", 32'(bus.fifo_full), 32'hFF);
        bus.port_valid = '0;

        // Reset while three ports hold words and a word is in flight
        do_reset();
        bus.m_ready = 1'b0;
        set_word(2, 8'h21);
        set_word(3, 8'h31);
        set_word(7, 8'h71);
        bus.port_valid = 8'h8C;
        tick();
        set_word(2, 8'h22);
        set_word(3, 8'h32);
        set_word(7, 8'h72);
        tick();
        check("mid_pre_valid", 32'(bus.m_valid), 32'd1);
        check("mid_pre_port", 32'(bus.m_port), 32'd2);
        check("mid_pre_busy", 32'(bus.collector_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_reset("mid_rst");
        tick();
        check("mid_hold_valid", 32'(bus.m_valid), 32'd0);
        check("mid_hold_busy", 32'(bus.collector_busy), 32'd0);
        bus.port_valid = '0;
        rst = 1'b0;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_after_valid", 32'(bus.m_valid), 32'd0);
            check("mid_after_busy", 32'(bus.collector_busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
